// File: rtl/winner_policy_pkg.sv
// Shared definitions for the epsilon-greedy next-hop selector: state codes,
// decay modes and default node-memory addresses.
package winner_policy_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DRAW    = 4'd1,
        ST_RD_CNT  = 4'd2,
        ST_REDUCE  = 4'd3,
        ST_RD_HOP  = 4'd4,
        ST_EXPLOIT = 4'd5,
        ST_FINISH  = 4'd6
    } state_t;

    localparam int NO_HOP_DEFAULT = 100;

    localparam int DECAY_NONE    = 0;
    localparam int DECAY_EXPLORE = 1;
    localparam int DECAY_ALWAYS  = 2;

    localparam logic [15:0] COUNT_ADDR_DEFAULT = 16'h068C;
    localparam logic [15:0] TABLE_BASE_DEFAULT = 16'h0668;

endpackage

// File: rtl/winner_policy_param_seq_modulo.sv
// Restoring remainder unit: computes dividend mod divisor one bit per cycle,
// taking exactly WORD_WIDTH cycles after start before the done pulse.
module seq_modulo #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH-1:0] divisor,
    output logic [WORD_WIDTH-1:0] remainder,
    output logic                  done
);

    localparam int CW = $clog2(WORD_WIDTH) + 1;

    logic [WORD_WIDTH-1:0] shift_q;
    logic [WORD_WIDTH-1:0] divisor_q;
    logic [WORD_WIDTH-1:0] rem_q;
    logic [CW-1:0]         cnt_q;
    logic                  running_q;
    logic [WORD_WIDTH:0]   trial;
    logic [WORD_WIDTH:0]   diff;

    assign trial     = {rem_q, shift_q[WORD_WIDTH-1]};
    assign diff      = trial - {1'b0, divisor_q};
    assign remainder = rem_q;

    // Shift the next dividend bit into the partial remainder and subtract
    // the divisor whenever it fits.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shift_q   <= dividend;
                divisor_q <= divisor;
                rem_q     <= '0;
                cnt_q     <= CW'(WORD_WIDTH - 1);
                running_q <= 1'b1;
            end else if (running_q) begin
                if (trial >= {1'b0, divisor_q})
                    rem_q <= diff[WORD_WIDTH-1:0];
                else
                    rem_q <= trial[WORD_WIDTH-1:0];
                shift_q <= shift_q << 1;
                if (cnt_q == '0) begin
                    running_q <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/winner_policy_param.sv
// Epsilon-greedy next-hop selector: explores a random better-neighbour table
// entry or exploits the best hop under margin/tolerance tests on Q-values.
module winner_policy_param
    import winner_policy_pkg::*;
#(
    parameter int                    WORD_WIDTH    = 16,
    parameter int                    FRAC_BITS     = 4,
    parameter logic [WORD_WIDTH-1:0] COUNT_ADDR    = COUNT_ADDR_DEFAULT,
    parameter logic [WORD_WIDTH-1:0] TABLE_BASE    = TABLE_BASE_DEFAULT,
    parameter int                    ENTRY_STRIDE  = 2,
    parameter int                    MAX_NEIGHBORS = 16,
    parameter int                    MEM_LAT       = 1,
    parameter int                    TOL_SHIFT     = 10,
    parameter int                    TOL_LO        = 1023,
    parameter int                    TOL_HI        = 1025,
    parameter int                    DECAY_MODE    = DECAY_EXPLORE,
    parameter int                    EPS_MIN       = 0,
    parameter int                    NO_HOP        = NO_HOP_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] my_best,
    input  logic [WORD_WIDTH-1:0] best_hop,
    input  logic [WORD_WIDTH-1:0] best_value,
    input  logic [WORD_WIDTH-1:0] best_neighbor_id,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    input  logic [WORD_WIDTH-1:0] rand_in,
    input  logic                  eps_load,
    input  logic [WORD_WIDTH-1:0] eps_init,
    input  logic [WORD_WIDTH-1:0] eps_step,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [WORD_WIDTH-1:0] mem_data,
    output logic [WORD_WIDTH-1:0] next_hop,
    output logic                  done,
    output logic                  busy,
    output logic                  explored,
    output logic [WORD_WIDTH-1:0] epsilon,
    output logic [3:0]            state_out
);

    // Products are kept wide enough that neither side of a margin test truncates.
    localparam int PW = 2 * WORD_WIDTH + TOL_SHIFT;
    localparam logic [2:0]            LAT_INIT = 3'(MEM_LAT - 1);
    localparam logic [WORD_WIDTH-1:0] STRIDE_W = WORD_WIDTH'(ENTRY_STRIDE);
    localparam logic [WORD_WIDTH-1:0] MAX_W    = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] NO_HOP_W = WORD_WIDTH'(NO_HOP);
    localparam logic [WORD_WIDTH-1:0] EPS_MIN_W = WORD_WIDTH'(EPS_MIN);

    state_t state, state_next;

    logic [WORD_WIDTH-1:0] s_rand;
    logic [WORD_WIDTH-1:0] s_my_best;
    logic [WORD_WIDTH-1:0] s_best_hop;
    logic [WORD_WIDTH-1:0] s_best_value;
    logic [WORD_WIDTH-1:0] s_best_id;
    logic [WORD_WIDTH-1:0] s_my_id;
    logic [WORD_WIDTH-1:0] s_eps_step;
    logic [2:0]            lat_q;

    logic                  explore_pick;
    logic [WORD_WIDTH-1:0] count_clamped;
    logic                  mod_start;
    logic                  mod_done;
    logic [WORD_WIDTH-1:0] mod_rem;
    logic [WORD_WIDTH-1:0] table_addr;

    logic [PW-1:0]         prod_l;
    logic [PW-1:0]         prod_a;
    logic [PW-1:0]         prod_b;
    logic [WORD_WIDTH-1:0] exploit_hop;

    logic [WORD_WIDTH:0]   eps_floor;
    logic [WORD_WIDTH-1:0] eps_decayed;
    logic                  decay_en;

    assign explore_pick  = (s_rand < epsilon);
    assign count_clamped = (mem_data > MAX_W) ? MAX_W : mem_data;
    assign table_addr    = TABLE_BASE + mod_rem * STRIDE_W;
    assign state_out     = state;

    assign prod_l = PW'(s_best_value) << TOL_SHIFT;
    assign prod_a = PW'(s_my_best) * PW'(TOL_LO);
    assign prod_b = PW'(s_my_best) * PW'(TOL_HI);

    always_comb begin
        exploit_hop = NO_HOP_W;
        if (prod_l < prod_a)
            exploit_hop = s_best_hop;
        else if ((prod_l < prod_b) && (s_best_id != s_my_id))
            exploit_hop = s_best_hop;
    end

    // The floor comparison runs one bit wider so eps_step + EPS_MIN never wraps.
    assign eps_floor   = {1'b0, s_eps_step} + (WORD_WIDTH+1)'(EPS_MIN);
    assign eps_decayed = ({1'b0, epsilon} >= eps_floor) ? (epsilon - s_eps_step) : EPS_MIN_W;
    assign decay_en    = (DECAY_MODE == DECAY_ALWAYS) ||
                         ((DECAY_MODE == DECAY_EXPLORE) && explored);

    seq_modulo #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_modulo (
        .clock     (clock),
        .reset     (reset),
        .start     (mod_start),
        .dividend  (rand_in),
        .divisor   (count_clamped),
        .remainder (mod_rem),
        .done      (mod_done)
    );

    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_rd_en  = 1'b0;
        mod_start  = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!eps_load && start)
                    state_next = ST_DRAW;
            end
            ST_DRAW: begin
                if (explore_pick) begin
                    mem_addr   = COUNT_ADDR;
                    mem_rd_en  = 1'b1;
                    state_next = ST_RD_CNT;
                end else begin
                    state_next = ST_EXPLOIT;
                end
            end
            ST_RD_CNT: begin
                if (lat_q == '0) begin
                    if (count_clamped == '0) begin
                        state_next = ST_EXPLOIT;
                    end else begin
                        mod_start  = 1'b1;
                        state_next = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                if (mod_done) begin
                    mem_addr   = table_addr;
                    mem_rd_en  = 1'b1;
                    state_next = ST_RD_HOP;
                end
            end
            ST_RD_HOP: begin
                if (lat_q == '0)
                    state_next = ST_FINISH;
            end
            ST_EXPLOIT: state_next = ST_FINISH;
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            s_rand       <= '0;
            s_my_best    <= '0;
            s_best_hop   <= '0;
            s_best_value <= '0;
            s_best_id    <= '0;
            s_my_id      <= '0;
            s_eps_step   <= '0;
            lat_q        <= '0;
            next_hop     <= NO_HOP_W;
            busy         <= 1'b0;
            explored     <= 1'b0;
            epsilon      <= eps_init;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (eps_load) begin
                        epsilon <= eps_init;
                    end else if (start) begin
                        s_rand       <= rand_in;
                        s_my_best    <= my_best;
                        s_best_hop   <= best_hop;
                        s_best_value <= best_value;
                        s_best_id    <= best_neighbor_id;
                        s_my_id      <= my_node_id;
                        s_eps_step   <= eps_step;
                        busy         <= 1'b1;
                    end
                end
                ST_DRAW: lat_q <= LAT_INIT;
                ST_RD_CNT: begin
                    if (lat_q != '0)
                        lat_q <= lat_q - 1'b1;
                end
                ST_REDUCE: lat_q <= LAT_INIT;
                ST_RD_HOP: begin
                    if (lat_q != '0) begin
                        lat_q <= lat_q - 1'b1;
                    end else begin
                        next_hop <= mem_data;
                        explored <= 1'b1;
                    end
                end
                ST_EXPLOIT: begin
                    next_hop <= exploit_hop;
                    explored <= 1'b0;
                end
                ST_FINISH: begin
                    busy <= 1'b0;
                    if (decay_en)
                        epsilon <= eps_decayed;
                end
                default: ;
            endcase
        end
    end

endmodule
